io_sched: RTL and testbench

I/O port scheduler that sits between a floating-point SAPHO processor core (with its int2float/float2int wrappers) and up to NPORT external streaming channels. It translates the processor's one-hot read strobes (req_in) and write strobes (out_en) into valid/ready handshakes. Each input port has a one-entry buffer, so a value is always ready when the processor reads it. Each output port has a one-entry holding register, so processor writes never stall. Per-port sticky underrun/overrun flags and a multi-strobe bus-error flag report scheduling violations, because the processor core has no stall input.

---
 rtl/io_sched_if.sv | 32 +++
 rtl/io_sched.sv | 104 ++++++++++
 tb/tb_io_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_sched_if.sv
// Processor-side strobes and streaming channels of the I/O scheduler.
// master = processor core plus external channel endpoints, slave = io_sched.
interface io_sched_if #(
    parameter int NPORT = 4,
    parameter int NBI   = 19,
    parameter int NBO   = 28
);
    logic [NPORT-1:0]     req_in;
    logic [NBI-1:0]       io_in;
    logic [NPORT-1:0]     out_en;
    logic [NBO-1:0]       io_out;
    logic [NPORT*NBI-1:0] s_data;
    logic [NPORT-1:0]     s_valid;
    logic [NPORT-1:0]     s_ready;
    logic [NPORT*NBO-1:0] m_data;
    logic [NPORT-1:0]     m_valid;
    logic [NPORT-1:0]     m_ready;
    logic                 clr_err;
    logic [NPORT-1:0]     underrun;
    logic [NPORT-1:0]     overrun;
    logic                 bus_err;

    modport master (
        output req_in, out_en, io_out, s_data, s_valid, m_ready, clr_err,
        input  io_in, s_ready, m_data, m_valid, underrun, overrun, bus_err
    );

    modport slave (
        input  req_in, out_en, io_out, s_data, s_valid, m_ready, clr_err,
        output io_in, s_ready, m_data, m_valid, underrun, overrun, bus_err
    );
endinterface

// File: rtl/io_sched.sv
// I/O port scheduler: turns the processor's one-hot read/write strobes into
// valid/ready handshakes. One-entry buffer per input port (reads never wait),
// one-entry holding register per output port (writes never stall). Because the
// core cannot be stalled, violations are reported through sticky flags.
module io_sched #(
    parameter int NPORT = 4,
    parameter int NBI   = 19,
    parameter int NBO   = 28
) (
    input logic        clk,
    input logic        rst,
    io_sched_if.slave  bus
);

    // Lowest set bit of v as a one-hot vector; extra strobes are ignored.
    function automatic logic [NPORT-1:0] lowest_one(input logic [NPORT-1:0] v);
        logic [NPORT-1:0] r;
        r = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [NPORT-1:0] v);
        return (v & (v - NPORT'(1))) != '0;
    endfunction

    logic [NPORT-1:0]     full;
    logic [NBI-1:0]       in_buf [NPORT];
    logic [NPORT*NBO-1:0] m_data_q;
    logic [NPORT-1:0]     m_valid_q;
    logic [NPORT-1:0]     underrun_q;
    logic [NPORT-1:0]     overrun_q;
    logic                 bus_err_q;

    logic [NPORT-1:0]     rd;
    logic [NPORT-1:0]     wr;
    logic [NPORT-1:0]     s_ready_w;
    logic [NBI-1:0]       io_in_w;

    assign rd        = lowest_one(bus.req_in);
    assign wr        = lowest_one(bus.out_en);
    // A buffer being read this cycle can take a new word in the same cycle.
    assign s_ready_w = ~full | rd;

    // Zero-latency read mux: stale contents are returned if the port is empty.
    always_comb begin
        io_in_w = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (rd[k]) io_in_w = in_buf[k];
        end
    end

    // Input buffers, output holding registers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= '0;
            underrun_q <= '0;
            overrun_q  <= '0;
            bus_err_q  <= 1'b0;
            for (int k = 0; k < NPORT; k++) in_buf[k] <= '0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                if (bus.s_valid[k] && s_ready_w[k]) begin
                    in_buf[k] <= bus.s_data[k*NBI +: NBI];
                    full[k]   <= 1'b1;
                end else if (rd[k]) begin
                    full[k]   <= 1'b0;
                end

                // A write wins over a completing handshake, so m_valid stays up.
                if (wr[k]) begin
                    m_data_q[k*NBO +: NBO] <= bus.io_out;
                    m_valid_q[k]           <= 1'b1;
                end else if (bus.m_ready[k]) begin
                    m_valid_q[k]           <= 1'b0;
                end
            end

            // Set events take priority over clr_err.
            underrun_q <= (underrun_q & ~{NPORT{bus.clr_err}}) | (rd & ~full);
            overrun_q  <= (overrun_q & ~{NPORT{bus.clr_err}})
                        | (wr & m_valid_q & ~bus.m_ready);
            bus_err_q  <= (bus_err_q & ~bus.clr_err)
                        | multi_hot(bus.req_in) | multi_hot(bus.out_en);
        end
    end

    assign bus.io_in    = io_in_w;
    assign bus.s_ready  = s_ready_w;
    assign bus.m_data   = m_data_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.underrun = underrun_q;
    assign bus.overrun  = overrun_q;
    assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_io_sched.sv
// Bench for io_sched: directed scenarios followed by random traffic, all
// compared against a per-port behavioural model of buffers, registers and flags.
module tb_io_sched;
    localparam int NPORT = 4;
    localparam int NBI   = 19;
    localparam int NBO   = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_sched_if #(.NPORT(NPORT), .NBI(NBI), .NBO(NBO)) bus ();

    io_sched #(.NPORT(NPORT), .NBI(NBI), .NBO(NBO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one entry per port.
    bit             full_m [NPORT];
    logic [NBI-1:0] buf_m  [NPORT];
    bit             mv_m   [NPORT];
    logic [NBO-1:0] md_m   [NPORT];
    bit             ur_m   [NPORT];
    bit             ov_m   [NPORT];
    bit             be_m;

    // Combinational outputs seen at the last sampled cycle.
    logic [NBI-1:0]   obs_io_in;
    logic [NPORT-1:0] obs_s_ready;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NPORT; k++) begin
            full_m[k] = 0; buf_m[k] = '0; mv_m[k] = 0; md_m[k] = '0;
            ur_m[k] = 0; ov_m[k] = 0;
        end
        be_m = 0;
    endtask

    function automatic int first_set(input logic [NPORT-1:0] v);
        for (int i = 0; i < NPORT; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NPORT*NBI-1:0] put_in(input int k, input logic [NBI-1:0] v);
        logic [NPORT*NBI-1:0] r;
        r = '0;
        r[k*NBI +: NBI] = v;
        return r;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic drive_cycle(input logic [NPORT-1:0] req, input logic [NPORT-1:0] oen,
                               input logic [NBO-1:0] iout, input logic [NPORT-1:0] sv,
                               input logic [NPORT*NBI-1:0] sd, input logic [NPORT-1:0] mr,
                               input logic clr);
        int r, w;
        logic [NBI-1:0]       exp_io;
        logic [NPORT-1:0]     exp_rdy, exp_mv, exp_ur, exp_ov;
        logic [NPORT*NBO-1:0] exp_md;
        bit             n_full [NPORT];
        logic [NBI-1:0] n_buf  [NPORT];
        bit             n_mv   [NPORT];
        logic [NBO-1:0] n_md   [NPORT];
        bit             n_ur   [NPORT];
        bit             n_ov   [NPORT];
        bit             n_be;

        bus.req_in = req; bus.out_en = oen; bus.io_out = iout;
        bus.s_valid = sv; bus.s_data = sd; bus.m_ready = mr; bus.clr_err = clr;

        @(negedge clk);
        r = first_set(req);
        w = first_set(oen);
        exp_io = (r >= 0) ? buf_m[r] : '0;
        for (int k = 0; k < NPORT; k++) begin
            exp_rdy[k] = !full_m[k] || (r == k);
            exp_mv[k]  = mv_m[k];
            exp_ur[k]  = ur_m[k];
            exp_ov[k]  = ov_m[k];
            exp_md[k*NBO +: NBO] = md_m[k];
        end
        obs_io_in   = bus.io_in;
        obs_s_ready = bus.s_ready;
        check("io_in",    128'(bus.io_in),    128'(exp_io));
        check("s_ready",  128'(bus.s_ready),  128'(exp_rdy));
        check("m_valid",  128'(bus.m_valid),  128'(exp_mv));
        check("m_data",   128'(bus.m_data),   128'(exp_md));
        check("underrun", 128'(bus.underrun), 128'(exp_ur));
        check("overrun",  128'(bus.overrun),  128'(exp_ov));
        check("bus_err",  128'(bus.bus_err),  128'(be_m));

        for (int k = 0; k < NPORT; k++) begin
            n_full[k] = full_m[k]; n_buf[k] = buf_m[k];
            n_mv[k] = mv_m[k]; n_md[k] = md_m[k];
            if (sv[k] && exp_rdy[k]) begin
                n_buf[k] = sd[k*NBI +: NBI];
                n_full[k] = 1;
            end else if (r == k) begin
                n_full[k] = 0;
            end
            if (w == k) begin
                n_md[k] = iout;
                n_mv[k] = 1;
            end else if (mv_m[k] && mr[k]) begin
                n_mv[k] = 0;
            end
            n_ur[k] = (ur_m[k] && !clr) || (r == k && !full_m[k]);
            n_ov[k] = (ov_m[k] && !clr) || (w == k && mv_m[k] && !mr[k]);
        end
        n_be = (be_m && !clr) || ($countones(req) > 1) || ($countones(oen) > 1);

        @(posedge clk);
        #1;
        for (int k = 0; k < NPORT; k++) begin
            full_m[k] = n_full[k]; buf_m[k] = n_buf[k]; mv_m[k] = n_mv[k];
            md_m[k] = n_md[k]; ur_m[k] = n_ur[k]; ov_m[k] = n_ov[k];
        end
        be_m = n_be;
    endtask

    task automatic idle(input logic [NPORT-1:0] mr);
        drive_cycle('0, '0, '0, '0, '0, mr, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_in = '0; bus.out_en = '0; bus.io_out = '0; bus.s_valid = '0;
        bus.s_data = '0; bus.m_ready = '0; bus.clr_err = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s_ready_in_reset", 128'(bus.s_ready), 128'(4'hF));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [NPORT-1:0] rand_strobe();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5) return '0;
        if (sel < 9) return NPORT'(1) << $urandom_range(0, NPORT - 1);
        return NPORT'($urandom);
    endfunction

    initial begin
        do_reset();
        idle('0);
        check("reset_m_valid", 128'(bus.m_valid), 128'(0));
        check("reset_flags", 128'({bus.underrun, bus.overrun, bus.bus_err}), 128'(0));

        // Fill port 2 then read it back in the same cycle as the strobe.
        drive_cycle('0, '0, '0, 4'b0100, put_in(2, 19'h12345), '0, 1'b0);
        drive_cycle(4'b0100, '0, '0, '0, '0, '0, 1'b0);
        check("t1_io_in", 128'(obs_io_in), 128'(19'h12345));
        check("t1_underrun", 128'(bus.underrun), 128'(0));
        idle('0);
        check("t1_ready_after", 128'(obs_s_ready[2]), 128'(1));

        // Read an empty port after reset.
        drive_cycle(4'b0001, '0, '0, '0, '0, '0, 1'b0);
        check("t2_io_in", 128'(obs_io_in), 128'(0));
        check("t2_underrun", 128'(bus.underrun), 128'(4'b0001));
        drive_cycle('0, '0, '0, '0, '0, '0, 1'b1);
        check("t2_cleared", 128'(bus.underrun), 128'(0));

        // Read and refill port 1 in the same cycle.
        drive_cycle('0, '0, '0, 4'b0010, put_in(1, 19'h00011), '0, 1'b0);
        drive_cycle(4'b0010, '0, '0, 4'b0010, put_in(1, 19'h00007), '0, 1'b0);
        check("t3_ready", 128'(obs_s_ready[1]), 128'(1));
        check("t3_old", 128'(obs_io_in), 128'(19'h00011));
        idle('0);
        check("t3_still_full", 128'(obs_s_ready[1]), 128'(0));
        drive_cycle(4'b0010, '0, '0, '0, '0, '0, 1'b0);
        check("t3_new", 128'(obs_io_in), 128'(19'h00007));

        // Output port 3: write, overrun, drain.
        drive_cycle('0, 4'b1000, 28'h0ABCDEF, '0, '0, '0, 1'b0);
        check("t4_valid", 128'(bus.m_valid[3]), 128'(1));
        check("t4_data", 128'(bus.m_data[3*NBO +: NBO]), 128'(28'h0ABCDEF));
        drive_cycle('0, 4'b1000, 28'h1, '0, '0, '0, 1'b0);
        check("t4_data2", 128'(bus.m_data[3*NBO +: NBO]), 128'(28'h1));
        check("t4_overrun", 128'(bus.overrun[3]), 128'(1));
        idle(4'b1000);
        check("t4_drained", 128'(bus.m_valid[3]), 128'(0));

        // Write during a completing handshake on port 0.
        drive_cycle('0, 4'b0001, 28'h0000123, '0, '0, '0, 1'b0);
        drive_cycle('0, 4'b0001, 28'h0000055, '0, '0, 4'b0001, 1'b0);
        check("t5_valid", 128'(bus.m_valid[0]), 128'(1));
        check("t5_data", 128'(bus.m_data[0 +: NBO]), 128'(28'h0000055));
        check("t5_no_overrun", 128'(bus.overrun[0]), 128'(0));
        idle(4'b0001);

        // Multi-strobe read, then clear colliding with a new bus error.
        drive_cycle(4'b0110, '0, '0, '0, '0, '0, 1'b0);
        check("t6_io_in", 128'(obs_io_in), 128'(19'h00007));
        check("t6_bus_err", 128'(bus.bus_err), 128'(1));
        drive_cycle(4'b0011, '0, '0, '0, '0, '0, 1'b1);
        check("t6_set_wins", 128'(bus.bus_err), 128'(1));
        drive_cycle('0, '0, '0, '0, '0, '0, 1'b1);
        check("t6_cleared", 128'(bus.bus_err), 128'(0));

        // Random traffic, with one reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            drive_cycle(rand_strobe(), rand_strobe(), NBO'($urandom), NPORT'($urandom),
                        (NPORT*NBI)'({$urandom, $urandom, $urandom}),
                        NPORT'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
